imem_axi_responder: RTL
=======================

Name: imem_axi_responder

Overview:
- AXI4 read-channel slave (responder) serving instruction/data reads from a synchronous single-port word memory.
- Sits between the core's AXI read initiators (instruction fetch, load unit) and a block-RAM-style array.
- Accepts one AR request at a time and streams 1 to 256 beats on R at up to one beat per cycle, honouring rready backpressure.

Parameters:
- ADDR_W, 15, byte-address width of araddr; memory word index is araddr[ADDR_W-1:2].
- ID_W, 4, width of arid/rid.
- MEM_WORDS, 8192, number of implemented 32-bit words; used only by the optional range check.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- araddr  in  ADDR_W  byte address of beat 0.
- arburst  in  2  00 FIXED, 01 INCR; 10/11 treated as INCR.
- arid  in  ID_W  transaction ID.
- arlen  in  8  beats minus 1.
- arsize  in  3  ignored; every beat is 4 bytes.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- rdata  out  32  read data.
- rid  out  ID_W  echo of the latched arid.
- rlast  out  1  high on the final beat.
- rresp  out  2  00 OKAY, 10 SLVERR (optional feature only).
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- mem_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W-2  memory word index.
- mem_rdata  in  32  memory data, valid one cycle after mem_en.

Behaviour:
- Reset (rst=1 at an edge):
  - arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, rid=0, mem_en=0, mem_addr=0.
  - FSM goes to IDLE and the output buffer is emptied.
  - An active burst is abandoned silently.
  - arready rises on the first cycle after rst deasserts.
- FSM states:
  - IDLE:
    - arready=1.
    - On arvalid&&arready, latch addr, len, burst and id; load beat counter = arlen; go to BURST.
  - BURST:
    - arready=0.
    - Issue one memory read (mem_en=1) per cycle while credit is available.
    - Credit: buffered beats + in-flight reads < 2.
    - Returning mem_rdata is pushed into a 2-entry output FIFO that drives rdata/rvalid/rlast/rid/rresp.
    - Go to DRAIN after the read with counter==0 is issued.
  - DRAIN:
    - No new reads.
    - Return to IDLE in the cycle after the rlast beat handshakes (rvalid&&rready&&rlast).
    - The next AR is therefore accepted no earlier than 1 cycle after that handshake.
- Address generation:
  - INCR adds 1 to the word index per beat, modulo 2^(ADDR_W-2); no 4 KB boundary check.
  - FIXED repeats the same index for every beat.
  - araddr[1:0] are ignored.
- Latency:
  - AR handshake at edge T: mem_en at T+1.
  - First rvalid at T+2.
  - With rready held at 1, beats are sustained 1 per cycle; an arlen=N burst completes its last beat at T+2+N.
- R handshake:
  - Once rvalid=1, rdata/rid/rlast/rresp hold stable until rvalid&&rready.
  - A simultaneous FIFO push and pop in the same cycle is legal and keeps the occupancy unchanged.
- Backpressure:
  - With rready=0, at most 2 beats are fetched ahead, then mem_en stays 0.
  - No beat is lost or duplicated under any rready pattern.
- rlast is high exactly on beat arlen; for arlen=0 the single beat carries rlast=1.
- rid equals the latched arid for every beat of the burst.

Optional Feature:
- IMEM_RANGE_CHECK_EN defined:
  - A beat whose word index >= MEM_WORDS returns rresp=10 and rdata=0.
  - The burst still completes with its full beat count and correct rlast.
- Undefined:
  - rresp is always 00.
  - Out-of-range indices alias modulo the physical array (mem_addr passed through).

Test Plan:
- Single beat: araddr=0x0010, arlen=0, arid=3, rready=1 -> mem_addr=4 one cycle after the handshake; rvalid two cycles after with rdata=mem[4], rlast=1, rid=3, rresp=00.
- INCR burst: araddr=0x0100, arlen=7, rready=1 -> 8 consecutive beats mem[64..71]; rlast only on beat 8; arready back to 1 one cycle after the last beat.
- FIXED burst: araddr=0x0020, arburst=00, arlen=3 -> four beats, all mem[8].
- Backpressure: arlen=5 with rready toggling 1,0,0,1,0,1,... -> exactly 6 beats in order; rdata stable while rvalid&&!rready; mem_en never leads by more than 2 beats.
- Wrap and reset: araddr=0x7FFC, arlen=1 -> mem[8191] then mem[0]; a new burst with rst asserted at beat 2 -> rvalid=0 next cycle, arready=1 the cycle after rst drops.
- IMEM_RANGE_CHECK_EN with MEM_WORDS=16: araddr=0x003C, arlen=1 -> beat 1 OKAY with mem[15]; beat 2 rresp=10, rdata=0, rlast=1.

Source files
------------

// File: rtl/imem_axi_responder.sv
// AXI4 read-channel responder in front of a synchronous single-port word memory.
// Optional IMEM_RANGE_CHECK_EN: beats at word index >= MEM_WORDS return SLVERR with zero data.
module imem_axi_responder #(
    parameter int ADDR_W    = 15,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [1:0]        arburst,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [ID_W-1:0]   rid,
    output logic              rlast,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int WA = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WA-1:0]   addr_q;
    logic [7:0]      cnt_q;
    logic            fixed_q;
    logic [ID_W-1:0] id_q;

    logic infl_q;
    logic infl_last_q;
    logic infl_err_q;

    logic [31:0] fifo_data [2];
    logic        fifo_last [2];
    logic [1:0]  fifo_resp [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic       ar_hs;
    logic       pop;
    logic       push;
    logic [2:0] occ;
    logic       issue;
    logic       beat_err;

    assign ar_hs = arvalid && arready;
    assign pop   = rvalid && rready;
    assign push  = infl_q;

    // A beat leaving this cycle frees its slot for the read issued now.
    assign occ   = {1'b0, count} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = !rst && (state == S_BURST) && (occ < 3'd2);

`ifdef IMEM_RANGE_CHECK_EN
    assign beat_err = (32'(addr_q) >= 32'(MEM_WORDS));
`else
    logic unused_cfg;
    assign beat_err   = 1'b0;
    assign unused_cfg = ^32'(MEM_WORDS);
`endif

    logic unused_in;
    assign unused_in = ^{arsize, araddr[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and AR ready.
    always_comb begin
        state_nx = state;
        arready  = 1'b0;
        case (state)
            S_IDLE: begin
                arready = !rst;
                if (arvalid && !rst) begin
                    state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (issue && (cnt_q == 8'd0)) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last[rd_ptr]) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Latch the request, then step address and remaining-beat count per issued read.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
            id_q    <= '0;
        end else if (ar_hs) begin
            addr_q  <= araddr[ADDR_W-1:2];
            cnt_q   <= arlen;
            fixed_q <= (arburst == 2'b00);
            id_q    <= arid;
        end else if (issue) begin
            if (!fixed_q) begin
                addr_q <= addr_q + 1'b1;
            end
            if (cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    // Side information for the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_err_q  <= 1'b0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= (cnt_q == 8'd0);
            infl_err_q  <= beat_err;
        end
    end

    // Two-entry output buffer; push and pop may occur together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
                fifo_resp[i] <= 2'b00;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= infl_err_q ? 32'd0 : mem_rdata;
                fifo_last[wr_ptr] <= infl_last_q;
                fifo_resp[wr_ptr] <= infl_err_q ? 2'b10 : 2'b00;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rvalid   = (count != 2'd0);
    assign rdata    = fifo_data[rd_ptr];
    assign rlast    = rvalid && fifo_last[rd_ptr];
    assign rresp    = fifo_resp[rd_ptr];
    assign rid      = id_q;
    assign mem_en   = issue;
    assign mem_addr = addr_q;

endmodule
